l1_cache_param: RTL and testbench
=================================

# l1_cache_param

Parametrised, blocking, write-through L1 data cache between the CPU load/store stage and the L2. Supports 1- or 2-way set associativity with per-set LRU, configurable line size and set count. Uses explicit req/ready handshakes on both the CPU and L2 sides instead of delay-based stalls. Fills a whole line from L2 on a read miss. Writes are no-write-allocate.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, CPU word width (multiple of 8)
- LINE_BYTES, 64, bytes per line (power of 2, ≥ DATA_W/8)
- SETS, 256, sets (power of 2)
- WAYS, 2, associativity; legal values 1 or 2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request valid; held stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored (word-aligned)
- cpu_wdata  in  DATA_W  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
- cpu_stall  out  1  cpu_req & ~cpu_ready (combinational)
- l2_req  out  1  L2 transaction valid
- l2_we  out  1  1 = word write, 0 = line read
- l2_addr  out  ADDR_W  word address (write) or line-aligned address (read)
- l2_wdata  out  DATA_W  write data
- l2_ack  in  1  L2 completion, one cycle
- l2_line  in  LINE_BYTES*8  fill data, valid with l2_ack; byte i = l2_line[8*i +: 8]

## Operation
- Address split: offset = log2(LINE_BYTES) bits; index = log2(SETS) bits; tag = remainder. Defaults give 6/8/18.
- Word packing is big-endian: cpu_rdata[DATA_W-1 -: 8] = line byte[offset], followed by offset+1, and so on.
- Hit: valid[way][index] and tag match. At most one way hits, by construction.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE, cpu_req=0: stay in IDLE.
- IDLE, load hit: latch word into cpu_rdata; LRU points to the other way; go to RESP.
- IDLE, load miss: drive l2_req=1, l2_we=0, l2_addr=line-aligned cpu_addr; go to FILL.
- IDLE, store: on hit, merge cpu_wdata into the line and update LRU. Hit or miss, drive l2_req=1, l2_we=1, l2_addr=cpu_addr, l2_wdata=cpu_wdata; go to WRITE. A store miss allocates nothing.
- FILL on l2_ack: choose victim = the first invalid way (way 0 first), otherwise the LRU way. Write l2_line, tag and valid into the victim; LRU points away from the victim. Latch the requested word from l2_line into cpu_rdata. Drop l2_req; go to RESP.
- WRITE on l2_ack: drop l2_req; go to RESP.
- RESP: cpu_ready=1; go to IDLE. cpu_req is not sampled in RESP.
- L2 handshake: l2_req/l2_we/l2_addr/l2_wdata stay stable from assertion through the cycle l2_ack is sampled. l2_ack is ignored while l2_req=0.
- WAYS=1: no LRU storage; the victim is always way 0.

## Timing
- Reset values:
  - Outputs: cpu_ready=0, cpu_rdata=0, l2_req=0, l2_we=0, l2_addr=0, l2_wdata=0.
  - Internal: state=IDLE; all valid bits and LRU bits cleared; data and tag arrays are not reset.
- Load hit: request sampled at edge N; cpu_ready high in cycle N+1. Back-to-back hits issue at most one per 2 cycles.
- Load miss: l2_req rises in cycle N+1. If l2_ack is sampled at edge M, cpu_ready is high in cycle M+1.
- Store: same as a load miss. cpu_ready follows l2_ack by one cycle.
- l2_ack in the same cycle l2_req rises is legal; fastest miss completes in 3 cycles.
- Reset mid-transaction: immediate return to IDLE and l2_req=0. The outstanding L2 transaction is abandoned, and an ack arriving after reset is ignored.
- Set aliasing: a fill into the same set as a just-hit way must evict the other way (LRU).

## Configuration
- L1_STATS_EN defined: adds ports hit_cnt (out, 32) and miss_cnt (out, 32).
  - Counted once per request when it leaves IDLE.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- L1_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package l1_cache_pkg holds:
  - the state enum (IDLE/FILL/WRITE/RESP);
  - width-derivation functions for offset, index and tag bits;
  - the byte-extract/merge functions implementing the big-endian word packing.
- Sub-module l1_way_select (combinational): per-way hit vector, hit way, and victim way from valid bits and the LRU bit.

## Test plan
- Reset, then load 0x0000_1000 → miss, l2_req=1 with l2_addr=0x0000_1000. Ack with line bytes 0x00..0x3F → cpu_rdata=0x00010203. Repeat load → hit, cpu_ready in cycle N+1, no l2_req.
- Load 0x0000_1004 after that fill → hit, cpu_rdata=0x04050607.
- Store 0xDEADBEEF to 0x0000_1008 (hit) → l2_we=1, l2_addr=0x0000_1008, cpu_ready one cycle after ack. Reload → 0xDEADBEEF with no L2 traffic.
- Store to uncached 0x0000_2000 → L2 write only. A following load of 0x0000_2000 misses.
- 2-way LRU:
  - Fill tag A then tag B into set 0x40 (addresses 0x0000_1000, 0x0000_5000); hit A.
  - Load tag C (0x0000_9000) → B evicted. A still hits; B misses.
- Assert rst while in FILL with l2_req=1 → l2_req=0 and state=IDLE immediately. A late l2_ack is ignored; the next load to the same address misses.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the parametrised L1 data cache.
// Words are packed big-endian inside a line: the lowest byte address is the word's MSB.
package l1_cache_pkg;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StResp} state_e;

    // Upper bounds for the generic byte helpers; callers size-cast in and out.
    localparam int unsigned MaxLineBits = 4096;
    localparam int unsigned MaxDataBits = 256;

    function automatic int unsigned offset_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned index_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_w,
                                             input int unsigned line_bytes,
                                             input int unsigned sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

    function automatic logic [MaxDataBits-1:0] get_word(input logic [MaxLineBits-1:0] line,
                                                        input int unsigned off,
                                                        input int unsigned nbytes);
        logic [MaxDataBits-1:0] w;
        w = '0;
        for (int unsigned j = 0; j < MaxDataBits / 8; j++) begin
            if (j < nbytes) w[8*(nbytes-1-j) +: 8] = line[8*(off+j) +: 8];
        end
        return w;
    endfunction

    function automatic logic [MaxLineBits-1:0] put_word(input logic [MaxLineBits-1:0] line,
                                                        input int unsigned off,
                                                        input int unsigned nbytes,
                                                        input logic [MaxDataBits-1:0] word);
        logic [MaxLineBits-1:0] l;
        l = line;
        for (int unsigned j = 0; j < MaxDataBits / 8; j++) begin
            if (j < nbytes) l[8*(off+j) +: 8] = word[8*(nbytes-1-j) +: 8];
        end
        return l;
    endfunction

endpackage

// File: rtl/l1_way_select.sv
// Hit detection and victim choice for one set of a 1- or 2-way cache.
module l1_way_select #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned TAG_W = 18
) (
    input  logic [WAYS-1:0]       valid,
    input  logic [WAYS*TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]      tag,
    input  logic                  lru,
    output logic [WAYS-1:0]       hit_vec,
    output logic                  hit,
    output logic                  hit_way,
    output logic                  victim_way
);

    always_comb begin
        hit_vec    = '0;
        hit_way    = 1'b0;
        victim_way = (WAYS == 2) ? lru : 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[w] && (tags[w*TAG_W +: TAG_W] == tag);
            if (hit_vec[w]) hit_way = 1'(w);
        end
        // Lowest-numbered invalid way wins over the LRU choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim_way = 1'(w);
        end
        hit = |hit_vec;
    end

endmodule

// File: rtl/l1_cache_param.sv
// Blocking write-through, no-write-allocate L1 data cache with req/ready handshakes.
// Optional L1_STATS_EN adds saturating hit/miss counters.
module l1_cache_param
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned SETS       = 256,
    parameter int unsigned WAYS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_ready,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_stall,
    output logic                    l2_req,
    output logic                    l2_we,
    output logic [ADDR_W-1:0]       l2_addr,
    output logic [DATA_W-1:0]       l2_wdata,
    input  logic                    l2_ack,
    input  logic [LINE_BYTES*8-1:0] l2_line
`ifdef L1_STATS_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);

    localparam int unsigned OffW      = offset_bits(LINE_BYTES);
    localparam int unsigned IdxW      = index_bits(SETS);
    localparam int unsigned TagW      = tag_bits(ADDR_W, LINE_BYTES, SETS);
    localparam int unsigned LineW     = LINE_BYTES * 8;
    localparam int unsigned WordBytes = DATA_W / 8;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                l2_req_q, l2_req_d, l2_we_q, l2_we_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d, req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   l2_wdata_q, l2_wdata_d;

    logic [LineW-1:0]    data_q [WAYS][SETS];
    logic [TagW-1:0]     tag_q  [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]     lru_q;

    logic [ADDR_W-1:0]   look_addr;
    logic [TagW-1:0]     look_tag;
    logic [IdxW-1:0]     look_idx;
    logic [OffW-1:0]     look_off;
    logic [WAYS-1:0]     way_valid, hit_vec;
    logic [WAYS*TagW-1:0] way_tags;
    logic                hit, hit_way, victim_way;
    logic [LineW-1:0]    hit_line, merged_line;
    logic                fill_en, store_hit_en, load_hit_en;

    // Outside IDLE the request is replayed from the latched address.
    assign look_addr = (state_q == StIdle) ? cpu_addr : req_addr_q;
    assign look_tag  = look_addr[ADDR_W-1 -: TagW];
    assign look_idx  = look_addr[OffW +: IdxW];
    assign look_off  = look_addr[OffW-1:0] & ~OffW'(WordBytes - 1);

    always_comb begin
        way_valid = '0;
        way_tags  = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_valid[w]               = valid_q[w][look_idx];
            way_tags[w*TagW +: TagW]   = tag_q[w][look_idx];
        end
    end

    l1_way_select #(
        .WAYS  (WAYS),
        .TAG_W (TagW)
    ) u_way_select (
        .valid      (way_valid),
        .tags       (way_tags),
        .tag        (look_tag),
        .lru        (lru_q[look_idx]),
        .hit_vec    (hit_vec),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    always_comb begin
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_line = data_q[w][look_idx];
        end
        merged_line = LineW'(put_word(MaxLineBits'(hit_line), 32'(look_off), WordBytes,
                                      MaxDataBits'(cpu_wdata)));
    end

    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        l2_req_d     = l2_req_q;
        l2_we_d      = l2_we_q;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        req_addr_d   = req_addr_q;
        fill_en      = 1'b0;
        store_hit_en = 1'b0;
        load_hit_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    req_addr_d = cpu_addr;
                    if (cpu_we) begin
                        store_hit_en = hit;
                        l2_req_d     = 1'b1;
                        l2_we_d      = 1'b1;
                        l2_addr_d    = cpu_addr;
                        l2_wdata_d   = cpu_wdata;
                        state_d      = StWrite;
                    end else if (hit) begin
                        load_hit_en = 1'b1;
                        rdata_d     = DATA_W'(get_word(MaxLineBits'(hit_line), 32'(look_off),
                                                       WordBytes));
                        state_d     = StResp;
                    end else begin
                        l2_req_d  = 1'b1;
                        l2_we_d   = 1'b0;
                        l2_addr_d = {cpu_addr[ADDR_W-1:OffW], OffW'(0)};
                        state_d   = StFill;
                    end
                end
            end
            StFill: begin
                if (l2_ack) begin
                    fill_en  = 1'b1;
                    rdata_d  = DATA_W'(get_word(MaxLineBits'(l2_line), 32'(look_off), WordBytes));
                    l2_req_d = 1'b0;
                    state_d  = StResp;
                end
            end
            StWrite: begin
                if (l2_ack) begin
                    l2_req_d = 1'b0;
                    state_d  = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rdata_q    <= '0;
            l2_req_q   <= 1'b0;
            l2_we_q    <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            l2_req_q   <= l2_req_d;
            l2_we_q    <= l2_we_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            req_addr_q <= req_addr_d;
        end
    end

    // LRU bit names the way to evict next; with one way it is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (victim_way == 1'(w)) valid_q[w][look_idx] <= 1'b1;
                end
                if (WAYS == 2) lru_q[look_idx] <= ~victim_way;
            end
            if ((load_hit_en || store_hit_en) && WAYS == 2) lru_q[look_idx] <= ~hit_way;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_en && victim_way == 1'(w)) begin
                data_q[w][look_idx] <= l2_line;
                tag_q[w][look_idx]  <= look_tag;
            end else if (store_hit_en && hit_vec[w]) begin
                data_q[w][look_idx] <= merged_line;
            end
        end
    end

    assign cpu_ready = (state_q == StResp);
    assign cpu_stall = cpu_req & ~cpu_ready;
    assign cpu_rdata = rdata_q;
    assign l2_req    = l2_req_q;
    assign l2_we     = l2_we_q;
    assign l2_addr   = l2_addr_q;
    assign l2_wdata  = l2_wdata_q;

`ifdef L1_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        leave_idle;

    assign leave_idle = (state_q == StIdle) && cpu_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (leave_idle) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_cache_param.sv
// Scoreboard bench for l1_cache_param: stimulus pushes expected responses, monitors check them.
module tb_l1_cache_param;

    typedef struct {
        logic [31:0] rdata;
        bit          is_load;
        int          lat;
        int          issue;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } l2_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic         cpu_ready, cpu_stall;
    logic [31:0]  cpu_rdata;
    logic         l2_req, l2_we, l2_ack;
    logic [31:0]  l2_addr, l2_wdata;
    logic [511:0] l2_line;
`ifdef L1_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ack_delay = 0;
    bit    hold_ack = 0;
    resp_t resp_q[$];
    l2_t   l2_q[$];
    resp_t mon_r;

    l1_cache_param dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .l2_req    (l2_req),
        .l2_we     (l2_we),
        .l2_addr   (l2_addr),
        .l2_wdata  (l2_wdata),
        .l2_ack    (l2_ack),
        .l2_line   (l2_line)
`ifdef L1_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Line byte i = i + (addr[31:12] - 1), so 0x1000 returns 0x00..0x3F.
    function automatic logic [511:0] make_line(input logic [31:0] a);
        logic [511:0] l;
        logic [7:0]   base;
        base = 8'((a >> 12) - 32'd1);
        for (int i = 0; i < 64; i++) l[8*i +: 8] = 8'(i) + base;
        return l;
    endfunction

    task automatic push_l2(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        l2_t e;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        l2_q.push_back(e);
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_l2, input int delay,
                          input int lat);
        resp_t r;
        bit    done;
        @(negedge clk);
        ack_delay = delay;
        if (exp_l2) push_l2(we, we ? addr : {addr[31:6], 6'b0}, wdata);
        r.rdata   = exp_rdata;
        r.is_load = !we;
        r.lat     = lat;
        r.issue   = cyc;
        resp_q.push_back(r);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1 check("stall_on_req", 32'(cpu_stall), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk);
            #1 done = cpu_ready;
        end
        cpu_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %08h got no ready required ready", addr);
        end
        @(negedge clk);
    endtask

    // CPU-side monitor: every ready pulse consumes one expected response.
    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready required none");
            end else begin
                mon_r = resp_q.pop_front();
                if (mon_r.is_load) check("rdata", cpu_rdata, mon_r.rdata);
                check("latency", 32'(cyc - mon_r.issue), 32'(mon_r.lat));
            end
        end
    end

    // L2 responder and request checker.
    initial begin : l2_model
        l2_t e;
        bit  hold;
        l2_ack  = 1'b0;
        l2_line = '0;
        forever begin
            @(negedge clk);
            if (l2_req && !rst) begin
                hold = 1'b0;
                if (l2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_l2: got addr %08h required no request", l2_addr);
                    e.addr = l2_addr;
                end else begin
                    e = l2_q.pop_front();
                    hold = hold_ack;
                    check("l2_we", 32'(l2_we), 32'(e.we));
                    check("l2_addr", l2_addr, e.addr);
                    if (e.we) check("l2_wdata", l2_wdata, e.wdata);
                end
                if (hold) begin
                    for (int k = 0; k < 50 && l2_req; k++) @(negedge clk);
                    @(negedge clk);
                    l2_ack  = 1'b1;
                    l2_line = make_line(e.addr);
                    @(negedge clk);
                    l2_ack  = 1'b0;
                end else begin
                    repeat (ack_delay) @(negedge clk);
                    check("l2_req_held", 32'(l2_req), 32'd1);
                    check("l2_addr_stable", l2_addr, e.addr);
                    l2_ack  = 1'b1;
                    l2_line = make_line(e.addr);
                    @(negedge clk);
                    l2_ack  = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit seen;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_l2_req", 32'(l2_req), 32'd0);
        check("rst_l2_we", 32'(l2_we), 32'd0);
        check("rst_l2_addr", l2_addr, 32'd0);
        check("rst_l2_wdata", l2_wdata, 32'd0);
        rst = 1'b0;

        //     we    addr          wdata         exp rdata     l2  delay lat
        do_req(1'b0, 32'h0000_1000, 32'h0,        32'h0001_0203, 1, 0, 2);
        do_req(1'b0, 32'h0000_1000, 32'h0,        32'h0001_0203, 0, 0, 1);
        do_req(1'b0, 32'h0000_1004, 32'h0,        32'h0405_0607, 0, 0, 1);
        do_req(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0,        1, 2, 4);
        do_req(1'b0, 32'h0000_1008, 32'h0,        32'hDEAD_BEEF, 0, 0, 1);
        do_req(1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0,        1, 0, 2);
        do_req(1'b0, 32'h0000_2000, 32'h0,        32'h0102_0304, 1, 0, 2);
        // Set 0x40: A=0x1000 in way 0, B=0x5000 fills way 1, touch A, C evicts B.
        do_req(1'b0, 32'h0000_5000, 32'h0,        32'h0405_0607, 1, 0, 2);
        do_req(1'b0, 32'h0000_1000, 32'h0,        32'h0001_0203, 0, 0, 1);
        do_req(1'b0, 32'h0000_9000, 32'h0,        32'h0809_0A0B, 1, 1, 3);
        do_req(1'b0, 32'h0000_1000, 32'h0,        32'h0001_0203, 0, 0, 1);
        do_req(1'b0, 32'h0000_5000, 32'h0,        32'h0405_0607, 1, 0, 2);

        // Reset while a fill is outstanding; the late ack must be ignored.
        @(negedge clk);
        hold_ack = 1'b1;
        push_l2(1'b0, 32'h0000_D000, 32'h0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_D000;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1 seen = l2_req;
        end
        check("fill_l2_req", 32'(seen), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_l2_req", 32'(l2_req), 32'd0);
        check("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("midrst_cpu_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        hold_ack = 1'b0;
        repeat (6) @(negedge clk);
        check("late_ack_l2_req", 32'(l2_req), 32'd0);
        check("late_ack_ready", 32'(cpu_ready), 32'd0);
        do_req(1'b0, 32'h0000_D000, 32'h0,        32'h0C0D_0E0F, 1, 0, 2);

        for (int k = 0; k < 50 && resp_q.size() != 0; k++) @(negedge clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("l2_q_drained", 32'(l2_q.size()), 32'd0);
`ifdef L1_STATS_EN
        check("hit_cnt", hit_cnt, 32'd0);
        check("miss_cnt", miss_cnt, 32'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
